sram_req_arbiter: RTL

- Shares one SRAM-like slave port (cache/AXI bridge side) between the instruction-fetch requester (preIF) and the data requester (EXE issue, MEM collects data_ok).
- Fixed-priority address-phase arbitration with a handshake lock.
- Keeps an in-order outstanding-transaction ID FIFO so each downstream data_ok/rdata goes back to the requester that issued it.

---
 rtl/sram_req_arbiter_if.sv | 48 ++++
 rtl/sram_req_arbiter.sv | 76 +++++++
 2 files changed

// File: rtl/sram_req_arbiter_if.sv
// rtl/sram_req_arbiter_if.sv - Fetch/data requester and downstream SRAM-like signal bundle
interface sram_req_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        sram_req;
    logic        sram_wr;
    logic [1:0]  sram_size;
    logic [31:0] sram_addr;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_wdata;
    logic        sram_addr_ok;
    logic        sram_data_ok;
    logic [31:0] sram_rdata;

    // Environment view: requesters plus the downstream responder.
    modport master (
        output inst_req, inst_addr,
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output sram_addr_ok, sram_data_ok, sram_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  sram_req, sram_wr, sram_size, sram_addr, sram_wstrb, sram_wdata
    );

    // Arbiter view.
    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  sram_addr_ok, sram_data_ok, sram_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output sram_req, sram_wr, sram_size, sram_addr, sram_wstrb, sram_wdata
    );
endinterface

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - Fixed-priority fetch/data arbiter onto one SRAM-like port with in-order response routing
module sram_req_arbiter #(
    parameter int OUTSTANDING = 2,
    parameter int ID_W        = $clog2(OUTSTANDING) + 1
) (
    input  logic                clk,
    input  logic                resetn,
    sram_req_arbiter_if.slave   bus
);
    localparam int                PTR_W    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(OUTSTANDING - 1);
    localparam logic [ID_W-1:0]   CNT_FULL = ID_W'(OUTSTANDING);

    logic                   lock_valid;
    logic                   lock_sel;
    logic [OUTSTANDING-1:0] id_fifo;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [ID_W-1:0]        count;

    logic full;
    logic sel;
    logic fire;
    logic pop;
    logic head;

    assign full = (count == CNT_FULL);
    // A stalled grant is held so the downstream never sees the address change mid-handshake.
    assign sel  = lock_valid ? lock_sel : bus.data_req;
    assign fire = bus.sram_req & bus.sram_addr_ok;
    assign pop  = bus.sram_data_ok & (count != '0);
    assign head = id_fifo[rd_ptr];

    // Gated by resetn so no request leaks downstream while reset is held.
    assign bus.sram_req   = resetn & ~full & (sel ? bus.data_req : bus.inst_req);
    assign bus.sram_wr    = sel & bus.data_wr;
    assign bus.sram_size  = sel ? bus.data_size : 2'd2;
    assign bus.sram_addr  = sel ? bus.data_addr : bus.inst_addr;
    assign bus.sram_wstrb = sel ? bus.data_wstrb : 4'h0;
    assign bus.sram_wdata = sel ? bus.data_wdata : 32'h0;

    assign bus.inst_addr_ok = fire & ~sel;
    assign bus.data_addr_ok = fire & sel;
    assign bus.inst_data_ok = pop & ~head;
    assign bus.data_data_ok = pop & head;
    assign bus.inst_rdata   = bus.sram_rdata;
    assign bus.data_rdata   = bus.sram_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_valid <= 1'b0;
            lock_sel   <= 1'b0;
            id_fifo    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            if (fire) begin
                lock_valid      <= 1'b0;
                id_fifo[wr_ptr] <= sel;
                wr_ptr          <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end else if (bus.sram_req) begin
                lock_valid <= 1'b1;
                lock_sel   <= sel;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({fire, pop})
                2'b10:   count <= count + ID_W'(1);
                2'b01:   count <= count - ID_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
